// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
//   skid_state_t   : occupancy state of a skid-buffered stage register
//   NOP_INSTR      : canonical NOP (addi x0, x0, 0) used as the bubble instruction
//   DEFAULT_BUBBLE : {NOP_INSTR, PC 0}, the IF/ID bubble payload
//   bubble_val()   : fits DEFAULT_BUBBLE to an arbitrary payload width
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam logic [31:0] NOP_INSTR      = 32'h00000013;
  localparam logic [63:0] DEFAULT_BUBBLE = {NOP_INSTR, 32'h0};

  // Zero-extends or truncates (keeping the low bits) the default bubble.
  function automatic logic [1023:0] bubble_val();
    logic [1023:0] v;
    v = '0;
    v[63:0] = DEFAULT_BUBBLE;
    return v;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline statistics.
//   clk   : clock
//   rst   : asynchronous active-high reset (count -> 0)
//   inc   : increment by one this cycle (ignored once at all-ones)
//   clr   : synchronous clear, wins over inc
//   count : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready depends only on the state flop, so there is no combinational path from
// out_ready back upstream; the skid entry absorbs the push that is already in flight
// when downstream stalls.
//   clk, rst             : clock, asynchronous active-high reset
//   flush                : synchronous discard of all held entries (beats push/pop)
//   in_valid/in_data     : upstream entry
//   in_ready             : stage can accept an entry
//   out_valid/out_data   : downstream entry (out_data = BUBBLE_VAL when not valid)
//   out_ready            : downstream accepts
//   occupancy            : entries held, 0..2
//   clr_stats            : synchronous clear of stall_cycles
//   stall_cycles         : saturating count of out_valid && !out_ready cycles
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W      = 64,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL  = DATA_W'(bubble_val()),
  parameter int unsigned        STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [1:0]             occupancy,
  input  logic                   clr_stats,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              push, pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // State and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state; skid always holds the younger entry.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    unique case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // main is reloaded with BUBBLE_VAL whenever the stage empties.
  assign out_data = main_q;

  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .clr   (clr_stats),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  localparam int unsigned   DW     = 64;
  localparam int unsigned   SW     = 4;
  localparam logic [63:0]   BUBBLE = 64'h00000013_00000000;
  localparam int            NVEC   = 15;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, clr_stats;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          exp_ov;
    logic [DW-1:0] exp_od;
    logic          exp_ir;
    logic [1:0]    exp_occ;
    logic [SW-1:0] exp_stall;
  } vec_t;

  vec_t vecs [NVEC];

  pipe_skid_reg #(
    .DATA_W      (DW),
    .STALL_CNT_W (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .occupancy    (occupancy),
    .clr_stats    (clr_stats),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [63:0] od,
                           input logic ir, input logic [1:0] occ);
    check({tag, " out_valid"}, 64'(out_valid), 64'(ov));
    check({tag, " out_data"},  out_data, od);
    check({tag, " in_ready"},  64'(in_ready), 64'(ir));
    check({tag, " occupancy"}, 64'(occupancy), 64'(occ));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic iv, input logic [63:0] id, input logic ordy,
                     input logic fl, input logic clr);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    clr_stats = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; clr_stats = 1'b0;

    // Stream of 8 back-to-back pushes, then drain.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 64'h100 + 64'(i), 1'b1, 1'b1, 64'h100 + 64'(i), 1'b1, 2'd1, 4'd0};
    end
    vecs[8]  = '{1'b0, 64'h0, 1'b1, 1'b0, BUBBLE, 1'b1, 2'd0, 4'd0};
    // A, B pushed into a stalled stage; C offered but refused while FULL.
    vecs[9]  = '{1'b1, 64'hA, 1'b0, 1'b1, 64'hA,  1'b1, 2'd1, 4'd0};
    vecs[10] = '{1'b1, 64'hB, 1'b0, 1'b1, 64'hA,  1'b0, 2'd2, 4'd1};
    vecs[11] = '{1'b1, 64'hC, 1'b0, 1'b1, 64'hA,  1'b0, 2'd2, 4'd2};
    vecs[12] = '{1'b1, 64'hC, 1'b1, 1'b1, 64'hB,  1'b1, 2'd1, 4'd2};
    vecs[13] = '{1'b1, 64'hC, 1'b1, 1'b1, 64'hC,  1'b1, 2'd1, 4'd2};
    vecs[14] = '{1'b0, 64'h0, 1'b1, 1'b0, BUBBLE, 1'b1, 2'd0, 4'd2};

    // Reset and idle release.
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("reset", 1'b0, BUBBLE, 1'b1, 2'd0);
    check("reset stall_cycles", 64'(stall_cycles), 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      cyc(vecs[i].iv, vecs[i].id, vecs[i].ordy, 1'b0, 1'b0);
      check_all($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_ir,
                vecs[i].exp_occ);
      check($sformatf("vec%0d stall_cycles", i), 64'(stall_cycles), 64'(vecs[i].exp_stall));
    end

    // Flush from FULL with a coincident in_valid: 0xDEAD must be dropped.
    cyc(1'b1, 64'h1111, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h2222, 1'b0, 1'b0, 1'b0);
    check("pre-flush occupancy", 64'(occupancy), 64'd2);
    cyc(1'b1, 64'hDEAD, 1'b0, 1'b1, 1'b0);
    check_all("flush", 1'b0, BUBBLE, 1'b1, 2'd0);
    check("flush stall_cycles", 64'(stall_cycles), 64'd4);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      check_all($sformatf("post-flush%0d", i), 1'b0, BUBBLE, 1'b1, 2'd0);
    end
    cyc(1'b1, 64'h55, 1'b0, 1'b0, 1'b0);
    check_all("push after flush", 1'b1, 64'h55, 1'b1, 2'd1);

    // Stall counter: clear, saturate at 15, clear wins over increment.
    cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    check("clr stall_cycles", 64'(stall_cycles), 64'd0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    check("saturated stall_cycles", 64'(stall_cycles), 64'd15);
    cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    check("clr over inc stall_cycles", 64'(stall_cycles), 64'd0);
    cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    check("restart stall_cycles", 64'(stall_cycles), 64'd1);

    // Asynchronous reset mid-cycle while FULL.
    cyc(1'b1, 64'h66, 1'b0, 1'b0, 1'b0);
    check("pre-reset occupancy", 64'(occupancy), 64'd2);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_all("async reset", 1'b0, BUBBLE, 1'b1, 2'd0);
    check("async reset stall_cycles", 64'(stall_cycles), 64'd0);
    #2 rst = 1'b0;
    cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check_all("after reset", 1'b0, BUBBLE, 1'b1, 2'd0);
    cyc(1'b1, 64'h77, 1'b1, 1'b0, 1'b0);
    check_all("push after reset", 1'b1, 64'h77, 1'b1, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
